// File: rtl/rf_pkg.sv
// Shared register-file definitions: data/address widths and the write bundle
// used both for buffer entries and for the register file write port.
package rf_pkg;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rf_wr_t;
endpackage

// File: rtl/rf_write_buffer_if.sv
// Bus bundle for rf_write_buffer: upstream handshake, register file write
// port, forwarding lookup and occupancy status.
interface rf_write_buffer_if
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic                       in_we;
   logic [ADDR_W-1:0]          in_addr;
   logic [DATA_W-1:0]          in_data;
   logic                       rf_ready;
   logic                       write_reg;
   logic [ADDR_W-1:0]          write_addr;
   logic [DATA_W-1:0]          write_data;
   logic [ADDR_W-1:0]          fwd_addr;
   logic                       fwd_hit;
   logic [DATA_W-1:0]          fwd_data;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       empty;

   modport slave (
      input  in_valid, in_we, in_addr, in_data, rf_ready, fwd_addr,
      output in_ready, write_reg, write_addr, write_data, fwd_hit, fwd_data,
             count, empty
   );

   modport master (
      output in_valid, in_we, in_addr, in_data, rf_ready, fwd_addr,
      input  in_ready, write_reg, write_addr, write_data, fwd_hit, fwd_data,
             count, empty
   );
endinterface

// File: rtl/rf_fwd_match.sv
// Priority search of the queued entries for a forwarding address; the
// youngest valid match (starting at wr_ptr-1 and walking back) wins.
module rf_fwd_match
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  rf_wr_t [DEPTH-1:0]         entries,
   input  logic   [DEPTH-1:0]         vld,
   input  logic   [$clog2(DEPTH)-1:0] wr_ptr,
   input  logic   [ADDR_W-1:0]        addr,
   output logic                       hit,
   output logic   [DATA_W-1:0]        data
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;

   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = wr_ptr - PTR_W'(i + 1);
         if (!hit && vld[idx] && entries[idx].addr == addr) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end
endmodule

// File: rtl/rf_write_buffer.sv
// In-order write buffer in front of the register file, drained one entry per
// rf_ready cycle. Forwarding search is built only when RF_WB_FWD_EN is defined.
module rf_write_buffer
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   rf_write_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]   vld_q, vld_d;
   rf_wr_t [DEPTH-1:0] mem_q, mem_d;
   rf_wr_t             head;
   logic               push, pop, empty, full;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   // in_ready looks only at registered occupancy, so a pop never frees a slot
   // for the same edge.
   assign bus.in_ready  = !rst && !full;
   assign bus.write_reg = !rst && !empty && bus.rf_ready;
   assign push          = bus.in_valid && bus.in_ready && bus.in_we;
   assign pop           = bus.write_reg;

   assign head           = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.write_addr = head.addr;
   assign bus.write_data = head.data;
   assign bus.count      = count_q;
   assign bus.empty      = empty;

   always_comb begin
      mem_d    = mem_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (pop) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (push) begin
         mem_d[wr_ptr_q] = '{addr: bus.in_addr, data: bus.in_data};
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
      end
   end

   // Payload needs no reset: entries are qualified by vld_q and count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef RF_WB_FWD_EN
   rf_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
      .entries (mem_q),
      .vld     (vld_q),
      .wr_ptr  (wr_ptr_q),
      .addr    (bus.fwd_addr),
      .hit     (bus.fwd_hit),
      .data    (bus.fwd_data)
   );
`else
   logic unused_fwd;
   assign unused_fwd   = ^{bus.fwd_addr, vld_q};
   assign bus.fwd_hit  = 1'b0;
   assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_rf_write_buffer.sv
// Self-checking bench for rf_write_buffer: vector table, reset corner case,
// and a continuously running queue-based scoreboard under random traffic.
module tb_rf_write_buffer;
   import rf_pkg::*;

`ifdef RF_WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   sb_on    = 1'b1;

   rf_write_buffer_if #(.DEPTH(DEPTH)) bus ();

   rf_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] a,
                        input logic [7:0] d, input logic rdy, input logic [2:0] fa);
      bus.in_valid = v;
      bus.in_we    = we;
      bus.in_addr  = a;
      bus.in_data  = d;
      bus.rf_ready = rdy;
      bus.fwd_addr = fa;
   endtask

   // ---------------- scoreboard ----------------
   rf_wr_t sbq[$];
   logic   sb_pop, sb_push;

   function automatic void model_fwd(input logic [2:0] fa, output logic hit,
                                     output logic [7:0] data);
      hit  = 1'b0;
      data = 8'h00;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (!hit && sbq[i].addr == fa) begin
            hit  = 1'b1;
            data = sbq[i].data;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         sbq.delete();
      end else begin
         sb_pop  = (sbq.size() > 0) && bus.rf_ready;
         sb_push = bus.in_valid && bus.in_we && (sbq.size() < DEPTH);
         if (sb_pop)  void'(sbq.pop_front());
         if (sb_push) sbq.push_back('{addr: bus.in_addr, data: bus.in_data});
      end
   end

   logic       m_hit;
   logic [7:0] m_fd;

   always @(negedge clk) begin
      if (sb_on) begin
         if (rst) begin
            chk("rst_write_reg", bus.write_reg, 0);
            chk("rst_count", bus.count, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_empty", bus.empty, 1);
            chk("rst_fwd_hit", bus.fwd_hit, 0);
            chk("rst_fwd_data", bus.fwd_data, 0);
         end else begin
            chk("sb_count", bus.count, sbq.size());
            chk("sb_in_ready", bus.in_ready, sbq.size() < DEPTH);
            chk("sb_empty", bus.empty, sbq.size() == 0);
            chk("sb_write_reg", bus.write_reg, (sbq.size() > 0) && bus.rf_ready);
            if (sbq.size() > 0) begin
               chk("sb_write_addr", bus.write_addr, sbq[0].addr);
               chk("sb_write_data", bus.write_data, sbq[0].data);
            end else begin
               chk("sb_write_addr_idle", bus.write_addr, 0);
               chk("sb_write_data_idle", bus.write_data, 0);
            end
            model_fwd(bus.fwd_addr, m_hit, m_fd);
            chk("sb_fwd_hit", bus.fwd_hit, FWD ? m_hit : 1'b0);
            chk("sb_fwd_data", bus.fwd_data, FWD ? m_fd : 8'h00);
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic       v, we;
      logic [2:0] a;
      logic [7:0] d;
      logic       rdy;
      logic [2:0] fa;
      int         cnt;
      logic       irdy, wr;
      logic [2:0] wa;
      logic [7:0] wd;
      logic       hit;
      logic [7:0] fd;
   } row_t;

   localparam int NROWS = 29;
   row_t tbl[NROWS];

   function automatic row_t mk(logic v, logic we, logic [2:0] a, logic [7:0] d,
                               logic rdy, logic [2:0] fa, int cnt, logic irdy,
                               logic wr, logic [2:0] wa, logic [7:0] wd,
                               logic hit, logic [7:0] fd);
      row_t r;
      r.v = v; r.we = we; r.a = a; r.d = d; r.rdy = rdy; r.fa = fa;
      r.cnt = cnt; r.irdy = irdy; r.wr = wr; r.wa = wa; r.wd = wd;
      r.hit = hit; r.fd = fd;
      return r;
   endfunction

   initial begin
      // single push, one-cycle latency, no bypass
      tbl[0]  = mk(0,0,3'd0,8'h00,1,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      tbl[1]  = mk(1,1,3'd3,8'h5A,1,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      tbl[2]  = mk(0,0,3'd0,8'h00,1,3'd0, 1,1,1,3'd3,8'h5A,0,8'h00);
      tbl[3]  = mk(0,0,3'd0,8'h00,1,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      // fill with rf_ready low, stall 5th, drain in order
      tbl[4]  = mk(1,1,3'd1,8'h11,0,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      tbl[5]  = mk(1,1,3'd2,8'h22,0,3'd1, 1,1,0,3'd1,8'h11,1,8'h11);
      tbl[6]  = mk(1,1,3'd3,8'h33,0,3'd2, 2,1,0,3'd1,8'h11,1,8'h22);
      tbl[7]  = mk(1,1,3'd4,8'h44,0,3'd5, 3,1,0,3'd1,8'h11,0,8'h00);
      tbl[8]  = mk(1,1,3'd5,8'h55,0,3'd4, 4,0,0,3'd1,8'h11,1,8'h44);
      tbl[9]  = mk(1,1,3'd5,8'h55,1,3'd3, 4,0,1,3'd1,8'h11,1,8'h33);
      tbl[10] = mk(1,1,3'd5,8'h55,1,3'd1, 3,1,1,3'd2,8'h22,0,8'h00);
      tbl[11] = mk(0,0,3'd0,8'h00,1,3'd5, 3,1,1,3'd3,8'h33,1,8'h55);
      tbl[12] = mk(0,0,3'd0,8'h00,1,3'd0, 2,1,1,3'd4,8'h44,0,8'h00);
      tbl[13] = mk(0,0,3'd0,8'h00,1,3'd0, 1,1,1,3'd5,8'h55,0,8'h00);
      tbl[14] = mk(0,0,3'd0,8'h00,1,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      // same-address entries: youngest forwarded, both issued oldest first
      tbl[15] = mk(1,1,3'd2,8'hAA,0,3'd2, 0,1,0,3'd0,8'h00,0,8'h00);
      tbl[16] = mk(1,1,3'd2,8'hBB,0,3'd2, 1,1,0,3'd2,8'hAA,1,8'hAA);
      tbl[17] = mk(0,0,3'd0,8'h00,0,3'd2, 2,1,0,3'd2,8'hAA,1,8'hBB);
      tbl[18] = mk(0,0,3'd0,8'h00,0,3'd5, 2,1,0,3'd2,8'hAA,0,8'h00);
      tbl[19] = mk(1,0,3'd6,8'h66,0,3'd6, 2,1,0,3'd2,8'hAA,0,8'h00);
      tbl[20] = mk(0,0,3'd0,8'h00,0,3'd6, 2,1,0,3'd2,8'hAA,0,8'h00);
      tbl[21] = mk(0,0,3'd0,8'h00,1,3'd2, 2,1,1,3'd2,8'hAA,1,8'hBB);
      tbl[22] = mk(0,0,3'd0,8'h00,1,3'd2, 1,1,1,3'd2,8'hBB,1,8'hBB);
      tbl[23] = mk(0,0,3'd0,8'h00,1,3'd2, 0,1,0,3'd0,8'h00,0,8'h00);
      // address 0 is ordinary; input port is not searched
      tbl[24] = mk(1,1,3'd0,8'h0F,1,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      tbl[25] = mk(0,0,3'd0,8'h00,1,3'd0, 1,1,1,3'd0,8'h0F,1,8'h0F);
      tbl[26] = mk(0,0,3'd0,8'h00,1,3'd0, 0,1,0,3'd0,8'h00,0,8'h00);
      // discard (in_we=0) with rf_ready high: no pulse
      tbl[27] = mk(1,0,3'd6,8'h77,1,3'd6, 0,1,0,3'd0,8'h00,0,8'h00);
      tbl[28] = mk(0,0,3'd0,8'h00,1,3'd6, 0,1,0,3'd0,8'h00,0,8'h00);

      rst = 1'b1;
      drive(0, 0, 3'd0, 8'h00, 1, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < NROWS; k++) begin
         @(posedge clk);
         #1;
         drive(tbl[k].v, tbl[k].we, tbl[k].a, tbl[k].d, tbl[k].rdy, tbl[k].fa);
         @(negedge clk);
         chk($sformatf("row%0d_count", k), bus.count, tbl[k].cnt);
         chk($sformatf("row%0d_in_ready", k), bus.in_ready, tbl[k].irdy);
         chk($sformatf("row%0d_write_reg", k), bus.write_reg, tbl[k].wr);
         if (tbl[k].wr || tbl[k].cnt == 0) begin
            chk($sformatf("row%0d_write_addr", k), bus.write_addr, tbl[k].wa);
            chk($sformatf("row%0d_write_data", k), bus.write_data, tbl[k].wd);
         end
         chk($sformatf("row%0d_fwd_hit", k), bus.fwd_hit, FWD ? tbl[k].hit : 1'b0);
         chk($sformatf("row%0d_fwd_data", k), bus.fwd_data, FWD ? tbl[k].fd : 8'h00);
      end

      // reset in the middle of a drain
      @(posedge clk); #1; drive(1, 1, 3'd1, 8'hA1, 0, 3'd0);
      @(posedge clk); #1; drive(1, 1, 3'd2, 8'hA2, 0, 3'd0);
      @(posedge clk); #1; drive(1, 1, 3'd3, 8'hA3, 0, 3'd0);
      @(posedge clk); #1; drive(0, 0, 3'd0, 8'h00, 1, 3'd0);
      @(negedge clk);
      chk("mid_first_write_reg", bus.write_reg, 1);
      chk("mid_first_write_data", bus.write_data, 8'hA1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_write_reg", bus.write_reg, 0);
      chk("mid_rst_count", bus.count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_no_stale_write", bus.write_reg, 0);
      end

      // random traffic, checked by the scoreboard
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         drive($urandom_range(0, 1), $urandom_range(0, 3) != 0,
               3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
      end
      @(posedge clk); #1;
      drive(0, 0, 3'd0, 8'h00, 1, 3'd0);
      repeat (DEPTH + 2) @(posedge clk);
      @(negedge clk);
      chk("final_drained_empty", bus.empty, 1);
      sb_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/rf_write_buffer.md
Name: rf_write_buffer

Overview:
Writer-side front end for the 8x8-bit register file. It accepts writeback results from the EX/MEM pipeline register over a valid/ready handshake and queues them in a small in-order FIFO. It drains one entry per cycle onto the register file write port (write_reg/write_addr/write_data) whenever the register file signals rf_ready. A forwarding lookup port exposes queued-but-unwritten values to the decode stage.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register address width (2**ADDR_W registers)
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  upstream result valid
in_ready  out  1  buffer can accept this cycle
in_we  in  1  result writes a register; 0 = consume and discard
in_addr  in  ADDR_W  destination register
in_data  in  DATA_W  result value
rf_ready  in  1  register file can take a write this cycle
write_reg  out  1  write strobe to register file
write_addr  out  ADDR_W  write address to register file
write_data  out  DATA_W  write data to register file
fwd_addr  in  ADDR_W  decode-stage read address for forwarding
fwd_hit  out  1  fwd_addr matches a queued entry
fwd_data  out  DATA_W  youngest matching queued value
count  out  clog2(DEPTH+1)  occupied entries
empty  out  1  count==0

Behaviour:
- Reset (async, rst=1): count=0, rd/wr pointers=0, all entry-valid bits cleared, write_reg=0, fwd_hit=0, fwd_data=0, empty=1, in_ready=0 while rst is high. Entry payload registers are don't-care.
- Occupancy states, derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- in_ready = !rst && count<DEPTH. It is registered-state based only; a same-cycle pop does not raise in_ready when FULL.
- Accept = in_valid && in_ready at a rising edge.
  - in_we=1: entry {in_addr,in_data} is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - in_we=0: the handshake completes but nothing is queued.
- Drain: write_reg = !empty && rf_ready (combinational). write_addr/write_data = head entry, driven 0 when empty. A pop occurs at the edge where write_reg=1; rd_ptr increments modulo DEPTH.
- Latency: an entry accepted at edge N is first presented on the write port in the cycle after edge N. There is no input-to-output bypass, even when EMPTY.
- Simultaneous push and pop: count unchanged and both pointers advance. Push to EMPTY with no pop: count becomes 1.
- Ordering: strictly in order. Two queued writes to the same address are both issued, oldest first. No coalescing.
- rf_ready low: head holds, write_reg=0, count is non-decreasing. The FIFO may fill, and then in_ready=0.
- Forwarding (combinational): search all occupied entries for addr==fwd_addr, including the head being written this cycle. The youngest match wins and fwd_hit=1. No match gives fwd_hit=0, fwd_data=0. The input port is not searched.
- Address 0 is an ordinary writable register; it gets no special treatment.
- Reset mid-operation: all queued entries are discarded. write_reg drops in the same cycle rst rises.

Optional Feature:
RF_WB_FWD_EN:
- Defined: forwarding search logic is built as above.
- Undefined: no comparators are built. fwd_hit and fwd_data are tied to 0, and fwd_addr is ignored. Port list is unchanged.

Decomposition:
- Shared package rf_pkg holds DATA_W, ADDR_W, NUM_REGS, and the typedef rf_wr_t {addr, data} that is used for FIFO entries and the write-port bundle.
- One natural sub-module, rf_fwd_match: a priority search over DEPTH entries, ordered youngest-first from wr_ptr-1. It is only instantiated under RF_WB_FWD_EN.

Test Plan:
- Reset then idle, rf_ready=1 -> write_reg=0, empty=1, count=0, in_ready=1 after rst falls.
- Push {addr=3,data=0x5A} at edge N, rf_ready=1 -> write_reg=1, write_addr=3, write_data=0x5A in cycle N+1 only; count back to 0 at edge N+1.
- rf_ready=0, push addrs 1,2,3,4 with data 0x11..0x44 -> count=4, in_ready=0, 5th valid stalls. Raise rf_ready -> writes 0x11,0x22,0x33,0x44 in order, one per cycle.
- Queue {2,0xAA} then {2,0xBB} with rf_ready=0, fwd_addr=2 -> fwd_hit=1, fwd_data=0xBB. fwd_addr=5 -> fwd_hit=0, fwd_data=0. Without RF_WB_FWD_EN -> fwd_hit=0 always.
- in_valid=1, in_we=0, addr=6 -> handshake completes, count unchanged, no write_reg pulse.
- Three entries queued, assert rst mid-drain -> write_reg=0 immediately, count=0. After release, no stale writes appear.
